// File: rtl/datamover_tile_sequencer.sv
// datamover_tile_sequencer
//   Job-level controller for the datamover streamer. One job is split into
//   cfg_n_tiles_i tiles. For each tile the block sends one start request to the
//   load source and one to the store sink, then waits for both done strobes.
//   After the last tile it waits for the TCDM FIFO to drain, then pulses done_o.
//
// Ports
//   clk_i, rst_ni, clear_i   clock, async active-low reset, sync clear
//   enable_i                 0 freezes FSM transitions. Handshakes and done
//                            capture still happen.
//   start_i, cfg_*           job start pulse and job configuration. cfg_* is
//                            latched when a start is accepted in IDLE.
//   src_* / snk_*            start handshake (req/ready), tile address and
//                            length, and done pulse for the source and sink
//   tcdm_fifo_empty_i        streamer FIFO empty flag
//   busy_o, done_o           busy_o is high outside IDLE. done_o is a one-cycle
//                            job-complete pulse.
//   tile_idx_o               index of the current tile
module datamover_tile_sequencer #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] cfg_src_base_i,
  input  logic [ADDR_W-1:0] cfg_dst_base_i,
  input  logic [ADDR_W-1:0] cfg_src_stride_i,
  input  logic [ADDR_W-1:0] cfg_dst_stride_i,
  input  logic [LEN_W-1:0]  cfg_tile_len_i,
  input  logic [CNT_W-1:0]  cfg_n_tiles_i,
  output logic              src_req_start_o,
  input  logic              src_ready_start_i,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic [LEN_W-1:0]  src_len_o,
  input  logic              src_done_i,
  output logic              snk_req_start_o,
  input  logic              snk_ready_start_i,
  output logic [ADDR_W-1:0] snk_addr_o,
  output logic [LEN_W-1:0]  snk_len_o,
  input  logic              snk_done_i,
  input  logic              tcdm_fifo_empty_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  tile_idx_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] snk_addr_q, snk_addr_d;
  logic [ADDR_W-1:0] src_stride_q, src_stride_d;
  logic [ADDR_W-1:0] dst_stride_q, dst_stride_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  n_tiles_q, n_tiles_d;
  logic [CNT_W-1:0]  tile_idx_q, tile_idx_d;
  logic              src_acc_q, src_acc_d;   // request already accepted this tile
  logic              snk_acc_q, snk_acc_d;
  logic              src_done_q, src_done_d; // sticky done flags
  logic              snk_done_q, snk_done_d;
  logic              done_q, done_d;

  logic src_hs, snk_hs, src_ok, snk_ok, last_tile;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      src_addr_q   <= '0;
      snk_addr_q   <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      len_q        <= '0;
      n_tiles_q    <= '0;
      tile_idx_q   <= '0;
      src_acc_q    <= 1'b0;
      snk_acc_q    <= 1'b0;
      src_done_q   <= 1'b0;
      snk_done_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_addr_q   <= src_addr_d;
      snk_addr_q   <= snk_addr_d;
      src_stride_q <= src_stride_d;
      dst_stride_q <= dst_stride_d;
      len_q        <= len_d;
      n_tiles_q    <= n_tiles_d;
      tile_idx_q   <= tile_idx_d;
      src_acc_q    <= src_acc_d;
      snk_acc_q    <= snk_acc_d;
      src_done_q   <= src_done_d;
      snk_done_q   <= snk_done_d;
      done_q       <= done_d;
    end
  end

  assign src_hs    = src_req_start_o & src_ready_start_i;
  assign snk_hs    = snk_req_start_o & snk_ready_start_i;
  // A done pulse in the same cycle counts the same as a flag that is already set.
  assign src_ok    = src_done_q | src_done_i;
  assign snk_ok    = snk_done_q | snk_done_i;
  assign last_tile = (tile_idx_q == n_tiles_q - CNT_W'(1));

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    src_addr_d   = src_addr_q;
    snk_addr_d   = snk_addr_q;
    src_stride_d = src_stride_q;
    dst_stride_d = dst_stride_q;
    len_d        = len_q;
    n_tiles_d    = n_tiles_q;
    tile_idx_d   = tile_idx_q;
    src_acc_d    = src_acc_q;
    snk_acc_d    = snk_acc_q;
    src_done_d   = src_done_q;
    snk_done_d   = snk_done_q;
    done_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && enable_i) begin
          src_addr_d   = cfg_src_base_i;
          snk_addr_d   = cfg_dst_base_i;
          src_stride_d = cfg_src_stride_i;
          dst_stride_d = cfg_dst_stride_i;
          len_d        = cfg_tile_len_i;
          n_tiles_d    = cfg_n_tiles_i;
          tile_idx_d   = '0;
          // An empty job goes straight to FINISH and issues no requests.
          if (cfg_n_tiles_i == '0 || cfg_tile_len_i == '0) state_d = S_FINISH;
          else                                             state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (src_hs) src_acc_d = 1'b1;
        if (snk_hs) snk_acc_d = 1'b1;
        if (src_done_i) src_done_d = 1'b1;
        if (snk_done_i) snk_done_d = 1'b1;
        // Leaving ISSUE does not depend on enable_i. A raised request must
        // complete its handshake.
        if ((src_acc_q | src_hs) && (snk_acc_q | snk_hs)) begin
          state_d   = S_WAIT;
          src_acc_d = 1'b0;
          snk_acc_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (src_ok && snk_ok && enable_i) begin
          src_done_d = 1'b0;
          snk_done_d = 1'b0;
          if (last_tile) begin
            state_d = S_DRAIN;
          end else begin
            state_d    = S_ISSUE;
            tile_idx_d = tile_idx_q + CNT_W'(1);
            src_addr_d = src_addr_q + src_stride_q;
            snk_addr_d = snk_addr_q + dst_stride_q;
          end
        end else begin
          src_done_d = src_ok;
          snk_done_d = snk_ok;
        end
      end
      S_DRAIN: begin
        if (tcdm_fifo_empty_i && enable_i) state_d = S_FINISH;
      end
      S_FINISH: begin
        // done_o is registered, so the pulse appears in the first IDLE cycle.
        if (enable_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_i) begin
      state_d      = S_IDLE;
      src_addr_d   = '0;
      snk_addr_d   = '0;
      src_stride_d = '0;
      dst_stride_d = '0;
      len_d        = '0;
      n_tiles_d    = '0;
      tile_idx_d   = '0;
      src_acc_d    = 1'b0;
      snk_acc_d    = 1'b0;
      src_done_d   = 1'b0;
      snk_done_d   = 1'b0;
      done_d       = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    busy_o          = (state_q != S_IDLE);
    src_req_start_o = (state_q == S_ISSUE) && !src_acc_q;
    snk_req_start_o = (state_q == S_ISSUE) && !snk_acc_q;
    src_addr_o      = src_addr_q;
    snk_addr_o      = snk_addr_q;
    src_len_o       = len_q;
    snk_len_o       = len_q;
    done_o          = done_q;
    tile_idx_o      = tile_idx_q;
  end

endmodule

// File: tb/tb_datamover_tile_sequencer.sv
module tb_datamover_tile_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, enable = 1'b1, start = 1'b0;
  logic [31:0] c_src, c_dst, c_ss, c_ds;
  logic [15:0] c_len, c_n;
  logic        src_req, src_rdy = 1'b0, src_done = 1'b0;
  logic        snk_req, snk_rdy = 1'b0, snk_done = 1'b0;
  logic [31:0] src_addr, snk_addr;
  logic [15:0] src_len, snk_len, tile_idx;
  logic        empty = 1'b1, busy, done;
  int total = 0, bad = 0;

  datamover_tile_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable), .start_i(start),
    .cfg_src_base_i(c_src), .cfg_dst_base_i(c_dst), .cfg_src_stride_i(c_ss),
    .cfg_dst_stride_i(c_ds), .cfg_tile_len_i(c_len), .cfg_n_tiles_i(c_n),
    .src_req_start_o(src_req), .src_ready_start_i(src_rdy), .src_addr_o(src_addr),
    .src_len_o(src_len), .src_done_i(src_done),
    .snk_req_start_o(snk_req), .snk_ready_start_i(snk_rdy), .snk_addr_o(snk_addr),
    .snk_len_o(snk_len), .snk_done_i(snk_done),
    .tcdm_fifo_empty_i(empty), .busy_o(busy), .done_o(done), .tile_idx_o(tile_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick(); @(posedge clk); #2; endtask

  task automatic set_cfg(input logic [31:0] s, d, ss, ds, input logic [15:0] l, n);
    c_src = s; c_dst = d; c_ss = ss; c_ds = ds; c_len = l; c_n = n;
  endtask

  task automatic go(); start = 1'b1; tick(); start = 1'b0; endtask
  task automatic accept_both(); src_rdy = 1'b1; snk_rdy = 1'b1; tick(); src_rdy = 1'b0; snk_rdy = 1'b0; endtask
  task automatic done_both(); src_done = 1'b1; snk_done = 1'b1; tick(); src_done = 1'b0; snk_done = 1'b0; endtask

  task automatic test_reset();
    set_cfg(0, 0, 0, 0, 0, 0);
    tick(); tick(); rst_n = 1'b1; tick();
    total++; if ({busy, done, src_req, snk_req} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, src_req, snk_req}); end
    total++; if ({src_addr, snk_addr, src_len, tile_idx} !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", {src_addr, snk_addr, src_len, tile_idx}); end
  endtask

  task automatic test_one_tile();
    set_cfg(32'h100, 32'h200, 0, 0, 8, 1); go();
    total++; if ({src_req, snk_req, busy} !== 3'b111) begin bad++; $display("FAIL one_req got=%b exp=111", {src_req, snk_req, busy}); end
    total++; if (src_addr !== 32'h100 || snk_addr !== 32'h200) begin bad++; $display("FAIL one_addr got=%h/%h exp=100/200", src_addr, snk_addr); end
    total++; if (src_len !== 16'd8 || snk_len !== 16'd8 || tile_idx !== 16'd0) begin bad++; $display("FAIL one_len got=%0d/%0d idx=%0d exp=8/8 idx=0", src_len, snk_len, tile_idx); end
    accept_both();
    total++; if ({src_req, snk_req} !== 2'b00) begin bad++; $display("FAIL one_req_drop got=%b exp=00", {src_req, snk_req}); end
    done_both(); // -> DRAIN
    total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL one_drain got=%b exp=10", {busy, done}); end
    tick(); // FINISH
    total++; if (done !== 1'b0) begin bad++; $display("FAIL one_finish_done got=%b exp=0", done); end
    tick(); // IDLE
    total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL one_done got=%b exp=01", {busy, done}); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL one_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_multi_tile();
    logic [31:0] es [3];
    logic [31:0] ed [3];
    es[0] = 32'h1000; es[1] = 32'h1040; es[2] = 32'h1080;
    ed[0] = 32'h2000; ed[1] = 32'h2080; ed[2] = 32'h2100;
    set_cfg(32'h1000, 32'h2000, 32'h40, 32'h80, 4, 3); go();
    for (int t = 0; t < 3; t++) begin
      total++; if (src_addr !== es[t] || snk_addr !== ed[t]) begin bad++; $display("FAIL multi_addr%0d got=%h/%h exp=%h/%h", t, src_addr, snk_addr, es[t], ed[t]); end
      total++; if (tile_idx !== 16'(t) || {src_req, snk_req} !== 2'b11) begin bad++; $display("FAIL multi_idx%0d got=%0d req=%b exp=%0d req=11", t, tile_idx, {src_req, snk_req}, t); end
      accept_both();
      done_both();
    end
    tick(); tick();
    total++; if ({busy, done} !== 2'b01 || tile_idx !== 16'd2) begin bad++; $display("FAIL multi_done got=%b idx=%0d exp=01 idx=2", {busy, done}, tile_idx); end
  endtask

  task automatic test_backpressure();
    set_cfg(32'h300, 32'h400, 0, 0, 2, 1); go();
    snk_rdy = 1'b1; tick(); snk_rdy = 1'b0;
    total++; if ({src_req, snk_req} !== 2'b10) begin bad++; $display("FAIL bp_snk_first got=%b exp=10", {src_req, snk_req}); end
    for (int i = 0; i < 4; i++) begin
      enable = (i >= 2);
      tick();
      total++; if ({src_req, snk_req} !== 2'b10 || src_addr !== 32'h300 || src_len !== 16'd2) begin bad++; $display("FAIL bp_hold%0d got=%b %h %0d exp=10 300 2", i, {src_req, snk_req}, src_addr, src_len); end
    end
    enable = 1'b1;
    src_rdy = 1'b1; tick(); src_rdy = 1'b0;
    total++; if ({src_req, snk_req, busy} !== 3'b001) begin bad++; $display("FAIL bp_wait got=%b exp=001", {src_req, snk_req, busy}); end
    done_both(); tick(); tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b exp=1", done); end
  endtask

  task automatic test_skew();
    int dones = 0;
    set_cfg(32'h500, 32'h600, 32'h10, 32'h10, 1, 2); go();
    src_rdy = 1'b1; snk_rdy = 1'b1; src_done = 1'b1; tick();
    src_rdy = 1'b0; snk_rdy = 1'b0; src_done = 1'b0;
    repeat (10) tick();
    total++; if (tile_idx !== 16'd0 || src_req !== 1'b0) begin bad++; $display("FAIL skew_hold0 got=%0d req=%b exp=0 req=0", tile_idx, src_req); end
    snk_done = 1'b1; tick(); snk_done = 1'b0;
    total++; if (tile_idx !== 16'd1 || src_req !== 1'b1 || src_addr !== 32'h510) begin bad++; $display("FAIL skew_adv got=%0d %b %h exp=1 1 510", tile_idx, src_req, src_addr); end
    accept_both();
    snk_done = 1'b1; tick(); snk_done = 1'b0;
    repeat (10) tick();
    total++; if ({tile_idx, src_req, busy, done} !== {16'd1, 3'b010}) begin bad++; $display("FAIL skew_hold1 got=%0d %b exp=1 010", tile_idx, {src_req, busy, done}); end
    src_done = 1'b1; tick(); src_done = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); if (done === 1'b1) dones++; end
    total++; if (dones != 1 || busy !== 1'b0) begin bad++; $display("FAIL skew_done got=%0d busy=%b exp=1 busy=0", dones, busy); end
  endtask

  task automatic test_zero();
    set_cfg(32'h10, 32'h20, 0, 0, 8, 0); go();
    total++; if ({src_req, snk_req, busy, done} !== 4'b0010) begin bad++; $display("FAIL zero_n got=%b exp=0010", {src_req, snk_req, busy, done}); end
    tick();
    total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL zero_n_done got=%b exp=01", {busy, done}); end
    set_cfg(32'h10, 32'h20, 0, 0, 0, 2); go();
    total++; if ({src_req, snk_req, done} !== 3'b000) begin bad++; $display("FAIL zero_len got=%b exp=000", {src_req, snk_req, done}); end
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_len_done got=%b exp=1", done); end
  endtask

  task automatic test_drain_delay();
    set_cfg(32'h700, 32'h800, 0, 0, 3, 1); empty = 1'b0; go();
    accept_both(); done_both();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL drain_hold%0d got=%b exp=10", i, {busy, done}); end
    end
    empty = 1'b1; tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL drain_finish got=%b exp=0", done); end
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL drain_done got=%b exp=1", done); end
  endtask

  task automatic test_enable();
    set_cfg(32'hA0, 32'hB0, 0, 0, 1, 1);
    enable = 1'b0; go();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_start got=%b exp=0", busy); end
    enable = 1'b1; go(); accept_both();
    enable = 1'b0; done_both(); tick(); tick();
    total++; if ({busy, src_req, done} !== 3'b100) begin bad++; $display("FAIL en_wait got=%b exp=100", {busy, src_req, done}); end
    enable = 1'b1; tick(); tick(); tick();
    total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL en_done got=%b exp=01", {busy, done}); end
  endtask

  task automatic test_clear_ignore();
    int dones = 0;
    set_cfg(32'h900, 32'hA00, 32'h20, 32'h20, 2, 2); go();
    set_cfg(32'h5555, 32'h6666, 0, 0, 9, 9); go();
    total++; if (src_addr !== 32'h900 || src_len !== 16'd2 || src_req !== 1'b1) begin bad++; $display("FAIL ignore_start got=%h %0d %b exp=900 2 1", src_addr, src_len, src_req); end
    accept_both(); done_both();
    total++; if (src_addr !== 32'h920 || tile_idx !== 16'd1) begin bad++; $display("FAIL clr_tile1 got=%h %0d exp=920 1", src_addr, tile_idx); end
    accept_both();
    clear = 1'b1; tick(); clear = 1'b0;
    total++; if ({busy, src_req, snk_req, done} !== 4'b0 || {src_addr, tile_idx} !== '0) begin bad++; $display("FAIL clr_state got=%b %h %0d exp=0000 0 0", {busy, src_req, snk_req, done}, src_addr, tile_idx); end
    src_done = 1'b1; snk_done = 1'b1; tick(); src_done = 1'b0; snk_done = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); if (done === 1'b1 || busy === 1'b1) dones++; end
    total++; if (dones != 0) begin bad++; $display("FAIL clr_no_done got=%0d exp=0", dones); end
  endtask

  task automatic test_wrap();
    set_cfg(32'hFFFFFFC0, 32'hFFFFFF00, 32'h80, 32'h100, 1, 2); go();
    accept_both(); done_both();
    total++; if (src_addr !== 32'h40 || snk_addr !== 32'h0) begin bad++; $display("FAIL wrap got=%h/%h exp=40/0", src_addr, snk_addr); end
    accept_both(); done_both(); tick(); tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b exp=1", done); end
  endtask

  initial begin
    test_reset();
    test_one_tile();
    test_multi_tile();
    test_backpressure();
    test_skew();
    test_zero();
    test_drain_delay();
    test_enable();
    test_clear_ignore();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
